// File: rtl/tone_sequencer_gen.sv
// tone_sequencer_gen: note-command driven square-wave generator with timed duration, rests, mute gate and abort.
module tone_sequencer_gen #(
  parameter int CNT_W     = 22,
  parameter int TICK_DIV  = 100000,
  parameter int DUR_W     = 12,
  parameter int DIV_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [3:0]       note,
  input  logic [2:0]       octave,
  input  logic [DUR_W-1:0] dur,
  input  logic             gate,
  input  logic             stop,
  output logic             speaker,
  output logic             busy,
  output logic             done
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] REST  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  function automatic logic [CNT_W-1:0] div_of(input logic [3:0] n, input logic [2:0] o);
    logic [CNT_W-1:0] b, d;
    case (n)
      4'd0:    b = CNT_W'(191113);
      4'd1:    b = CNT_W'(180388);
      4'd2:    b = CNT_W'(170262);
      4'd3:    b = CNT_W'(160705);
      4'd4:    b = CNT_W'(151685);
      4'd5:    b = CNT_W'(143172);
      4'd6:    b = CNT_W'(135139);
      4'd7:    b = CNT_W'(127551);
      4'd8:    b = CNT_W'(120395);
      4'd9:    b = CNT_W'(113636);
      4'd10:   b = CNT_W'(107259);
      default: b = CNT_W'(101239);
    endcase
    d = (o < 3'd4) ? b << (3'd4 - o) : b >> (o - 3'd4);
    d = d >> DIV_SHIFT;
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  logic [1:0]       state;
  logic             t;
  logic [CNT_W-1:0] hcnt, div_cur, div_in;
  logic [PW-1:0]    pres;
  logic [DUR_W-1:0] dcnt;
  logic [3:0]       note_q;
  logic [2:0]       oct_q;
  logic             hz, tick, expire;

  assign div_cur    = div_of(note_q, oct_q);
  assign div_in     = div_of(note, octave);
  assign hz         = hcnt == '0;
  assign tick       = pres == '0;
  assign expire     = tick && dcnt == DUR_W'(1);
  assign note_ready = state == IDLE;
  assign busy       = state != IDLE;

  // On expiry or abort a high tone is never cut short: it either ends on this
  // very half-period boundary or finishes its half period in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      t       <= 1'b0;
      speaker <= 1'b0;
      done    <= 1'b0;
      hcnt    <= '0;
      pres    <= '0;
      dcnt    <= '0;
      note_q  <= '0;
      oct_q   <= '0;
    end else begin
      done    <= 1'b0;
      speaker <= t & gate;
      case (state)
        IDLE: if (note_valid) begin
          note_q <= note;
          oct_q  <= octave;
          hcnt   <= div_in - 1'b1;
          pres   <= TICK_MAX;
          dcnt   <= dur;
          if (dur == '0) done <= 1'b1;
          else state <= (note > 4'd11) ? REST : PLAY;
        end
        PLAY: begin
          hcnt <= hz ? div_cur - 1'b1 : hcnt - 1'b1;
          pres <= tick ? TICK_MAX : pres - 1'b1;
          if (tick) dcnt <= dcnt - 1'b1;
          if (expire || stop) begin
            if (!t || hz) begin
              state <= IDLE;
              t     <= 1'b0;
              done  <= 1'b1;
            end else state <= DRAIN;
          end else if (hz) t <= ~t;
        end
        REST: begin
          pres <= tick ? TICK_MAX : pres - 1'b1;
          if (tick) dcnt <= dcnt - 1'b1;
          if (expire || stop) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          hcnt <= hz ? div_cur - 1'b1 : hcnt - 1'b1;
          if (hz) begin
            state <= IDLE;
            t     <= 1'b0;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tone_sequencer_gen.sv
// tb_tone_sequencer_gen: directed tests of tone_sequencer_gen with DIV_SHIFT=10, TICK_DIV=10.
module tb_tone_sequencer_gen;
  logic        clk, rst_n, note_valid, note_ready, gate, stop, speaker, busy, done;
  logic [3:0]  note;
  logic [2:0]  octave;
  logic [11:0] dur;
  int assertions, failures;
  int chg[$];
  int done_at, ndone, busy_gap, gate_hi_cnt;
  logic acc_busy;

  tone_sequencer_gen #(.CNT_W(22), .TICK_DIV(10), .DUR_W(12), .DIV_SHIFT(10)) dut (
    .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
    .note(note), .octave(octave), .dur(dur), .gate(gate), .stop(stop),
    .speaker(speaker), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] n, input logic [2:0] o, input logic [11:0] d, input logic s);
    @(negedge clk);
    note = n; octave = o; dur = d; stop = s; note_valid = 1'b1;
    @(posedge clk); #1;
    note_valid = 1'b0; stop = 1'b0;
  endtask

  // Edge k counts clock edges after the accepting edge; samples taken #1 after each.
  task automatic run(input logic [3:0] n, input logic [2:0] o, input logic [11:0] d,
                     input int gl, input int gh, input int sk, input logic s);
    logic prev;
    prev = speaker;
    chg.delete();
    done_at = -1; ndone = 0; busy_gap = 0; gate_hi_cnt = 0;
    issue(n, o, d, s);
    acc_busy = busy;
    for (int k = 1; k <= 4000; k++) begin
      @(posedge clk); #1;
      if (speaker !== prev) chg.push_back(k);
      prev = speaker;
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end else if (done_at < 0 && busy !== 1'b1) busy_gap++;
      if (gl >= 0 && k > gl && k <= gh && speaker === 1'b1) gate_hi_cnt++;
      if (k == gl) gate = 1'b0;
      if (k == gh) gate = 1'b1;
      if (k == sk) stop = 1'b1;
      if (k == sk + 1) stop = 1'b0;
      if (done_at >= 0 && k >= done_at + 5) break;
    end
  endtask

  task automatic test_reset;
    int nd;
    repeat (3) @(posedge clk);
    #1;
    assertions++;
    if ({speaker, busy, note_ready, done} !== 4'b0010) begin
      failures++;
      $display("FAIL reset_init: spk/busy/rdy/done=%b required 0010", {speaker, busy, note_ready, done});
    end
    @(negedge clk) rst_n = 1'b1;
    issue(4'd9, 3'd4, 12'd50, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    assertions++;
    if (speaker !== 1'b1) begin
      failures++;
      $display("FAIL reset_midplay_pre: speaker=%b required 1", speaker);
    end
    #2 rst_n = 1'b0;
    #1;
    assertions++;
    if ({speaker, busy, note_ready, done} !== 4'b0010) begin
      failures++;
      $display("FAIL reset_midplay: spk/busy/rdy/done=%b required 0010", {speaker, busy, note_ready, done});
    end
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy !== 1'b0 || speaker !== 1'b0) nd++;
    end
    assertions++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL reset_release: %0d bad samples required 0", nd);
    end
  endtask

  task automatic test_a4;
    int exp_chg[4] = '{111, 221, 331, 441};
    run(4'd9, 3'd4, 12'd50, -1, -1, -1, 1'b0);
    assertions++;
    if (chg.size() !== 4) begin
      failures++;
      $display("FAIL a4_nchg: %0d edges required 4", chg.size());
    end else
      for (int i = 0; i < 4; i++) begin
        assertions++;
        if (chg[i] !== exp_chg[i]) begin
          failures++;
          $display("FAIL a4_edge%0d: at %0d required %0d", i, chg[i], exp_chg[i]);
        end
      end
    assertions++;
    if (done_at !== 500 || ndone !== 1) begin
      failures++;
      $display("FAIL a4_done: at %0d count %0d required 500 count 1", done_at, ndone);
    end
    assertions++;
    if (note_ready !== 1'b1 || busy !== 1'b0 || busy_gap !== 0) begin
      failures++;
      $display("FAIL a4_idle: rdy=%b busy=%b gap=%0d required 1 0 0", note_ready, busy, busy_gap);
    end
  endtask

  task automatic test_a7_c0;
    int exp_chg[4] = '{14, 27, 40, 53};
    run(4'd9, 3'd7, 12'd5, -1, -1, -1, 1'b0);
    assertions++;
    if (chg.size() !== 4) begin
      failures++;
      $display("FAIL a7_nchg: %0d edges required 4", chg.size());
    end else
      for (int i = 0; i < 4; i++) begin
        assertions++;
        if (chg[i] !== exp_chg[i]) begin
          failures++;
          $display("FAIL a7_edge%0d: at %0d required %0d", i, chg[i], exp_chg[i]);
        end
      end
    assertions++;
    if (done_at !== 52 || ndone !== 1) begin
      failures++;
      $display("FAIL a7_drain_done: at %0d count %0d required 52 count 1", done_at, ndone);
    end
    run(4'd0, 3'd0, 12'd3, -1, -1, -1, 1'b0);
    assertions++;
    if (chg.size() !== 0 || done_at !== 30 || ndone !== 1) begin
      failures++;
      $display("FAIL c0: edges %0d done %0d count %0d required 0 30 1", chg.size(), done_at, ndone);
    end
  endtask

  task automatic test_rest;
    run(4'd13, 3'd4, 12'd20, -1, -1, -1, 1'b0);
    assertions++;
    if (chg.size() !== 0 || busy_gap !== 0 || done_at !== 200 || ndone !== 1) begin
      failures++;
      $display("FAIL rest: edges %0d gap %0d done %0d count %0d required 0 0 200 1",
               chg.size(), busy_gap, done_at, ndone);
    end
    issue(4'd9, 3'd4, 12'd0, 1'b0);
    assertions++;
    if (done !== 1'b1 || busy !== 1'b0 || note_ready !== 1'b1) begin
      failures++;
      $display("FAIL dur0: done=%b busy=%b rdy=%b required 1 0 1", done, busy, note_ready);
    end
    @(posedge clk); #1;
    assertions++;
    if (done !== 1'b0 || busy !== 1'b0 || speaker !== 1'b0) begin
      failures++;
      $display("FAIL dur0_after: done=%b busy=%b spk=%b required 0 0 0", done, busy, speaker);
    end
  endtask

  task automatic test_gate;
    int exp_chg[2] = '{401, 441};
    run(4'd9, 3'd4, 12'd50, 100, 400, -1, 1'b0);
    assertions++;
    if (gate_hi_cnt !== 0) begin
      failures++;
      $display("FAIL gate_mute: %0d high samples required 0", gate_hi_cnt);
    end
    assertions++;
    if (chg.size() !== 2) begin
      failures++;
      $display("FAIL gate_nchg: %0d edges required 2", chg.size());
    end else
      for (int i = 0; i < 2; i++) begin
        assertions++;
        if (chg[i] !== exp_chg[i]) begin
          failures++;
          $display("FAIL gate_edge%0d: at %0d required %0d", i, chg[i], exp_chg[i]);
        end
      end
    assertions++;
    if (done_at !== 500 || ndone !== 1) begin
      failures++;
      $display("FAIL gate_done: at %0d count %0d required 500 count 1", done_at, ndone);
    end
  endtask

  task automatic test_stop;
    run(4'd9, 3'd4, 12'd50, -1, -1, 150, 1'b0);
    assertions++;
    if (chg.size() !== 2 || done_at !== 220 || ndone !== 1) begin
      failures++;
      $display("FAIL stop_play: edges %0d done %0d count %0d required 2 220 1", chg.size(), done_at, ndone);
    end else begin
      assertions++;
      if (chg[1] !== 221) begin
        failures++;
        $display("FAIL stop_fall: at %0d required 221", chg[1]);
      end
    end
    run(4'd0, 3'd0, 12'd3, -1, -1, -1, 1'b1);
    assertions++;
    if (acc_busy !== 1'b1 || done_at !== 30 || ndone !== 1) begin
      failures++;
      $display("FAIL stop_idle_accept: busy %b done %0d count %0d required 1 30 1", acc_busy, done_at, ndone);
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2, stall_err;
    logic b;
    d1 = -1; d2 = -1; stall_err = 0; b = 1'b0;
    @(negedge clk);
    note = 4'd9; octave = 3'd7; dur = 12'd1; stop = 1'b0; note_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (d1 < 0 && note_ready !== 1'b0) stall_err++;
      if (d1 >= 0 && k == d1 + 1) begin
        b = busy;
        note_valid = 1'b0;
      end
      if (d2 >= 0 && k >= d2 + 3) break;
    end
    note_valid = 1'b0;
    assertions++;
    if (d1 !== 10 || stall_err !== 0) begin
      failures++;
      $display("FAIL b2b_first: done %0d stall_err %0d required 10 0", d1, stall_err);
    end
    assertions++;
    if (b !== 1'b1 || d2 !== 21) begin
      failures++;
      $display("FAIL b2b_second: busy %b done %0d required 1 21", b, d2);
    end
  endtask

  initial begin
    assertions = 0; failures = 0;
    rst_n = 1'b0; note_valid = 1'b0; note = '0; octave = '0; dur = '0; gate = 1'b1; stop = 1'b0;
    test_reset;
    test_a4;
    test_a7_c0;
    test_rest;
    test_gate;
    test_stop;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/tone_sequencer_gen.md
Name: tone_sequencer_gen

Overview:
- Parametrised successor to the single fixed-pitch speaker tone block.
- Accepts note commands (semitone, octave, duration) over a valid/ready handshake.
- Generates a square wave on `speaker` for exactly the commanded duration, then reports completion.
- Sits between the keyboard/song-sequencer logic and the board speaker pin; supports rests, a mute gate and abort.

Parameters:
- CNT_W, 22: width of the half-period counter; must hold the largest divider (octave 0, C).
- TICK_DIV, 100000: clk cycles per duration tick (1 ms at 100 MHz).
- DUR_W, 12: width of the duration field, in ticks.
- DIV_SHIFT, 0: extra right-shift applied to every table divider (simulation speed-up; 0 in hardware).

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- note_valid  in  1  command valid
- note_ready  out  1  block can accept a command; high only in IDLE
- note  in  4  semitone 0=C .. 11=B; 12..15 = rest
- octave  in  3  octave 0..7; 4 = table octave
- dur  in  DUR_W  duration in ticks
- gate  in  1  0 forces speaker low; counters keep running
- stop  in  1  abort the current note
- speaker  out  1  square-wave output
- busy  out  1  high in PLAY, REST, DRAIN
- done  out  1  one-cycle pulse when a command finishes

Behaviour:
- Reset (async, rst_n=0): state IDLE; speaker=0, tone register=0, done=0, busy=0, note_ready=1; all counters 0.
- Half-period table, octave 4 at 100 MHz, index C..B: 191113, 180388, 170262, 160705, 151685, 143172, 135139, 127551, 120395, 113636, 107259, 101239.
- Divider DIV = table[note] << (4-octave) when octave<4, else table[note] >> (octave-4); the result is then >> DIV_SHIFT. Compute at full CNT_W width.
- If DIV < 2, clamp DIV to 2.
- Accept: note_valid & note_ready on a clk edge.
  - Latch note, octave and dur; load the half-period counter with DIV-1; load the tick prescaler with TICK_DIV-1; load the duration counter with dur.
  - Next state: PLAY if note<=11, REST if note>=12. If dur==0: stay IDLE and pulse done next cycle, no sound.
- States: IDLE, PLAY, REST, DRAIN.
- Internal tone register T:
  - PLAY: half-period counter decrements; at 0 it reloads DIV-1 and T toggles. First toggle occurs DIV cycles after acceptance.
  - REST: T held 0.
- Output: speaker = T & gate, registered, so speaker lags T by one cycle. When gate is low, counters and T continue.
- Duration:
  - Prescaler counts down; at 0 it reloads and the duration counter decrements.
  - When the duration counter reaches 0, the note has lasted exactly dur*TICK_DIV cycles.
  - At expiry: if T==0, go to IDLE and pulse done on the same edge; if T==1, go to DRAIN.
- DRAIN: half-period counter continues; at its next 0, T goes to 0, then IDLE with done. This guarantees no truncated high pulse.
- stop (sampled high):
  - In PLAY: behaves as immediate expiry (DRAIN or IDLE).
  - In REST: go to IDLE with done.
  - Ignored in IDLE and DRAIN. In IDLE, a simultaneous note_valid is still accepted.
- Commands are accepted only in IDLE. note_valid held while busy is simply stalled (no queue). A new command can be accepted the cycle after done.
- Reset asserted mid-note: immediate return to reset values, with no done pulse.

Test Plan (DIV_SHIFT=10, TICK_DIV=10):
1. Reset mid-PLAY, then release.
   - Required: speaker=0, busy=0, note_ready=1, no done pulse.
2. Play A4 (note=9, octave=4, dur=50), gate=1.
   - DIV=110; speaker toggles every 110 cycles.
   - Note lasts 500 cycles, plus drain if T=1; then done pulses once and note_ready=1.
3. Play A7 (note=9, octave=7, dur=5).
   - DIV=13; 50 cycles; speaker period 26 cycles.
   - Play C0 (note=0, octave=0): DIV=2986 with dur=3, expect no toggle before expiry; done after 30 cycles.
4. Rest (note=13, dur=20) with gate=1.
   - speaker stays 0 for 200 cycles; busy high; done pulse at cycle 200.
   - Then a dur=0 command: done one cycle later, state stays IDLE.
5. PLAY with gate toggled low for 300 cycles.
   - speaker=0 throughout that window; on gate release, phase continues from T (not restarted); total duration unchanged.
6. stop raised while T=1.
   - speaker falls at the next half-period boundary, then done.
   - stop in IDLE together with note_valid: command accepted.
   - note_valid held during busy: accepted only after done.
